// File: rtl/alu_operand_issue.sv
// Operand-issue stage: integer register file, rs1/rs2 read, B select and an
// ALU-facing output register with valid/ready handshake. Optional macro: ISSUE_WB_BYPASS_EN.
module alu_operand_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [3:0]      ctrl_in,
  input  logic [AW-1:0]   rd_in,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A_out,
  output logic [XLEN-1:0] B_out,
  output logic [3:0]      ctrl_out,
  output logic [AW-1:0]   rd_out
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [AW-1:0]   rd_q, rd_d;

  logic            accept;
  logic            wb_we;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_we    = wb_en && (wb_addr != '0);

  always_comb begin
    rs1_val = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_val = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef ISSUE_WB_BYPASS_EN
    // wb_we already excludes x0, so a zero index never picks up wb_data
    if (wb_we && (wb_addr == rs1_addr)) rs1_val = wb_data;
    if (wb_we && (wb_addr == rs2_addr)) rs2_val = wb_data;
`endif
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we) regs_d[wb_addr] = wb_data;
    regs_d[0] = '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      a_d         = rs1_val;
      b_d         = use_imm ? imm : rs2_val;
      ctrl_d      = ctrl_in;
      rd_d        = rd_in;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      rd_q        <= '0;
    end else begin
      regs_q      <= regs_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign A_out     = a_q;
  assign B_out     = b_q;
  assign ctrl_out  = ctrl_q;
  assign rd_out    = rd_q;

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Operand-issue stage directly upstream of the ALU.
- Holds the 32-entry integer register file and reads rs1/rs2. Selects B from rs2 or the immediate.
- Registers A, B and the 4-bit ALU control code into an output stage that drives the ALU inputs A, B and Control_in.
- Valid/ready handshake on both sides allows the ALU side to stall. The writeback port writes results back into the register file.

Parameters:
- XLEN, 32, data width of registers, A, B, imm, wb_data.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, register address width; must satisfy 2**AW == NREGS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage can accept an instruction this cycle
- rs1_addr  input  AW  source register 1 index
- rs2_addr  input  AW  source register 2 index
- imm  input  XLEN  sign-extended immediate from decode
- use_imm  input  1  1: B = imm; 0: B = reg[rs2]
- ctrl_in  input  4  ALU control code, passed through unchanged
- rd_in  input  AW  destination index, passed through for writeback
- wb_en  input  1  writeback write enable
- wb_addr  input  AW  writeback destination
- wb_data  input  XLEN  writeback data
- out_valid  output  1  A_out/B_out/ctrl_out/rd_out are valid
- out_ready  input  1  ALU side consumes this cycle
- A_out  output  XLEN  to ALU A
- B_out  output  XLEN  to ALU B
- ctrl_out  output  4  to ALU Control_in
- rd_out  output  AW  destination index travelling with the op

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; A_out, B_out, ctrl_out, rd_out = 0.
  - All registers cleared to 0.
  - Takes effect immediately, mid-stall included. Any held op is discarded.
- in_ready = !out_valid || out_ready (combinational). No combinational path from in_valid to in_ready.
- Accept: on a rising edge with in_valid && in_ready, the output register loads:
  - A_out = rd(rs1_addr)
  - B_out = use_imm ? imm : rd(rs2_addr)
  - ctrl_out = ctrl_in; rd_out = rd_in
  - out_valid becomes 1.
- Drain: on an edge with out_valid && out_ready && !(in_valid) → out_valid becomes 0. Output data holds its last value.
- Stall: while out_valid && !out_ready, all outputs hold bit-for-bit stable. in_ready=0.
- Latency: one cycle from accept to out_valid. Full throughput of 1 op/cycle when out_ready stays high.
- Read function rd(i):
  - i==0 → 0.
  - Otherwise reg[i], subject to the bypass rule in Optional Feature.
- Writeback:
  - On an edge with wb_en && wb_addr!=0, reg[wb_addr] = wb_data.
  - wb_en with wb_addr==0 is ignored; reg[0] stays 0.
  - Writeback is independent of the handshake and happens during stalls too.
- Captured operands are not updated by later writebacks. A held op keeps the values sampled at accept.
- rs1_addr==rs2_addr is legal; both ports return the same value.
- ctrl_in values 4'b1001–4'b1111 pass through unmodified; the ALU treats them as its default case.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN
- Defined:
  - If wb_en && wb_addr!=0 && wb_addr==rsN_addr in the same cycle as an accept, that operand takes wb_data (write-first).
  - Applies independently to rs1 and rs2. Not applied to rs2 when use_imm=1.
- Not defined: the accept reads the pre-write register value (read-first). Decode must then insert a one-cycle bubble on such hazards.

Test Plan:
- Reset/x0:
  - Stimulus: assert rst_n=0 mid-stall with out_valid=1; release; wb_en=1, wb_addr=0, wb_data=32'hDEADBEEF; then issue rs1=0, rs2=0.
  - Required: immediately out_valid=0 and outputs 0; after release, A_out=0, B_out=0.
- Basic issue:
  - Stimulus: write x5=32'h00000007, x6=32'hFFFFFFFE; issue rs1=5, rs2=6, use_imm=0, ctrl_in=4'b0001, rd_in=7.
  - Required: next cycle out_valid=1, A_out=7, B_out=32'hFFFFFFFE, ctrl_out=4'b0001, rd_out=7.
- Immediate select:
  - Stimulus: rs1=5, rs2=6, use_imm=1, imm=32'hFFFFF800.
  - Required: B_out=32'hFFFFF800, A_out=7.
- Stall:
  - Stimulus: hold out_ready=0 for 3 cycles with in_valid=1 carrying a new op; write x5=32'h1 during the stall.
  - Required: in_ready=0, outputs unchanged (A_out still 7). The new op appears the cycle after out_ready=1.
- Back-to-back:
  - Stimulus: 4 consecutive ops with out_ready=1.
  - Required: 4 consecutive out_valid cycles, in order, no bubbles.
- Same-cycle writeback hazard:
  - Stimulus: accept rs1=9 while wb writes x9=32'h12345678; x9 previously 0.
  - Required: A_out=32'h12345678 with ISSUE_WB_BYPASS_EN defined; A_out=0 without it.
